// File: rtl/square_if.sv
// Operand/result bundle for the square unit; rem_b and err exist only with SQUARE_REM_EN.
// master drives requests, slave is the square unit itself.
interface square_if;
    logic        start;
    logic [7:0]  y_b;
    logic        ready;
    logic        busy;
    logic [15:0] x_b;
`ifdef SQUARE_REM_EN
    logic [8:0]  rem_b;
    logic        err;

    modport master (output start, y_b, rem_b, input ready, busy, x_b, err);
    modport slave  (input start, y_b, rem_b, output ready, busy, x_b, err);
`else
    modport master (output start, y_b, input ready, busy, x_b);
    modport slave  (input start, y_b, output ready, busy, x_b);
`endif
endinterface

// File: rtl/square.sv
// Shift-add squarer: x_b = y_b*y_b (+ rem_b when SQUARE_REM_EN is defined, err flags rem_b > 2*y_b).
// Latency: 9 cycles from the accepting edge to ready, one result per 10 cycles at most.
// Backpressure: start is taken only while ready; requests seen while busy are dropped.
module square (
    input  logic     clk,
    input  logic     rst,
    square_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mplier;
    logic [7:0]  mcand;
    logic [15:0] acc;
    logic [2:0]  step;
    logic [15:0] x_reg;
    logic        accept;

    assign accept    = (state == IDLE) && bus.start;
    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.x_b   = x_reg;

`ifdef SQUARE_REM_EN
    logic [8:0] rem;
    logic       rem_ok;
    logic       err_reg;

    assign bus.err = err_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = WORK;
            WORK:    if (step == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            step   <= '0;
            x_reg  <= '0;
`ifdef SQUARE_REM_EN
            rem     <= '0;
            rem_ok  <= 1'b0;
            err_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mplier <= bus.y_b;
                        mcand  <= bus.y_b;
                        acc    <= '0;
                        step   <= '0;
`ifdef SQUARE_REM_EN
                        // A remainder above 2*y would exceed the next square; flag it now
                        rem    <= bus.rem_b;
                        rem_ok <= (bus.rem_b <= {bus.y_b, 1'b0});
`endif
                    end
                end
                WORK: begin
                    if (mplier[0]) acc <= acc + ({8'h00, mcand} << step);
                    mplier <= mplier >> 1;
                    step   <= step + 3'd1;
                end
                DONE: begin
`ifdef SQUARE_REM_EN
                    x_reg   <= rem_ok ? acc + {7'd0, rem} : acc;
                    err_reg <= ~rem_ok;
`else
                    x_reg   <= acc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square.sv
// Directed scoreboard bench for square: stimulus pushes expected results, a monitor pops on each completion.
module tb_square;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    square_if bus ();
    square dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int y;
        int rem;
        int x;
        int e;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic last_rst;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Monitor: a completion is busy->ready not caused by reset
    initial begin : mon
        logic        prev_busy = 1'b0;
        int          bcnt      = 0;
        logic [15:0] held      = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (last_rst === 1'b1) begin
                bcnt = 0;
                held = '0;
            end else if (prev_busy && bus.ready === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got x_b=%0d want none", bus.x_b);
                end else begin
                    e = q.pop_front();
                    chk("x_b", bus.x_b, e.x);
                    chk("latency", bcnt, 9);
`ifdef SQUARE_REM_EN
                    chk("err", bus.err, e.e);
                    chk("sqrt_rem", bus.x_b - isqrt(bus.x_b) * isqrt(bus.x_b), e.e ? 0 : e.rem);
`endif
                    chk("sqrt_root", isqrt(bus.x_b), e.y);
                end
                held = bus.x_b;
                bcnt = 0;
            end else if (bus.ready === 1'b1 && !prev_busy) begin
                chk("x_b_hold", bus.x_b, held);
            end
            if (bus.busy === 1'b1) bcnt++;
            prev_busy = (bus.busy === 1'b1);
        end
    end

    task automatic wait_level(input string name, input logic lvl);
        int n = 0;
        while (bus.busy !== lvl && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy !== lvl) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy=%b want %b", name, bus.busy, lvl);
        end
    endtask

    task automatic do_op(input int y, input int rem, input int x, input int e, input bit poke);
        bus.y_b = 8'(y);
`ifdef SQUARE_REM_EN
        bus.rem_b = 9'(rem);
`endif
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        q.push_back('{y, rem, x, e});
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            bus.y_b   = ~bus.y_b;
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_level("op", 1'b0);
    endtask

    initial begin : watchdog
        #300000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        int y;
        int rem;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.y_b   = '0;
`ifdef SQUARE_REM_EN
        bus.rem_b = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x_b", bus.x_b, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(0,   0, 0,     0, 1'b0);
        do_op(255, 0, 65025, 0, 1'b1);
        do_op(16,  0, 256,   0, 1'b0);
        do_op(13,  0, 169,   0, 1'b1);

        // start held high: one accept every 10 cycles, operand changes while busy are ignored
        bus.y_b   = 8'd3;
        bus.start = 1'b1;
        wait_level("hold0", 1'b1);
        t0 = cyc;
        q.push_back('{3, 0, 9, 0});
        bus.y_b = 8'd7;
        wait_level("hold1a", 1'b0);
        wait_level("hold1b", 1'b1);
        chk("spacing1", cyc - t0, 10);
        t0 = cyc;
        q.push_back('{7, 0, 49, 0});
        bus.y_b = 8'd200;
        wait_level("hold2a", 1'b0);
        wait_level("hold2b", 1'b1);
        chk("spacing2", cyc - t0, 10);
        q.push_back('{200, 0, 40000, 0});
        bus.y_b = 8'd55;
        repeat (6) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_level("hold3", 1'b0);

        // reset at N+4 mid-WORK discards the operation
        bus.y_b   = 8'd100;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_x_b", bus.x_b, 0);
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_over_start_busy", bus.busy, 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_x_b", bus.x_b, 0);

`ifdef SQUARE_REM_EN
        do_op(255, 510, 65535, 0, 1'b0);
        do_op(255, 511, 65025, 1, 1'b0);
        do_op(0,   1,   0,     1, 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
            y   = $urandom_range(0, 255);
            rem = 0;
`ifdef SQUARE_REM_EN
            rem = $urandom_range(0, 2 * y);
`endif
            do_op(y, rem, y * y + rem, 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  input  1  request to begin an operation.
REQ-004 SHALL have ports: y_b  input  8  unsigned root operand, sampled on acceptance.
REQ-005 SHALL have ports: rem_b  input  9  unsigned remainder operand, sampled on acceptance (only with SQUARE_REM_EN).
REQ-006 SHALL have ports: ready  output  1  idle, result valid, start may be accepted.
REQ-007 SHALL have ports: busy  output  1  operation in progress.
REQ-008 SHALL have ports: x_b  output  16  unsigned result, registered.
REQ-009 SHALL have ports: err  output  1  remainder out of range (only with SQUARE_REM_EN).

Function
REQ-010 SHALL implement FSM states IDLE, WORK, DONE; busy = (state != IDLE); ready = (state == IDLE).
REQ-011 SHALL accept start only when state is IDLE and start=1 at edge N; on acceptance: latch y_b into an 8-bit multiplier register and an 8-bit multiplicand register, clear the 16-bit accumulator, clear the 3-bit step counter, go to WORK.
REQ-012 SHALL ignore start while busy; no queuing, latched operands unaffected.
REQ-013 SHALL in WORK, one step per cycle on edges N+1..N+8, LSB first: if multiplier bit0=1, add (multiplicand << step) to the accumulator; shift multiplier right 1; increment counter.
REQ-014 SHALL leave WORK for DONE on the edge that performs step 7 (edge N+8).
REQ-015 SHALL at edge N+9 in DONE load x_b with the final value, go to IDLE; ready=1 and x_b valid from edge N+9 onward.
REQ-016 SHALL give a fixed latency of 9 cycles from the acceptance edge to ready, independent of operand value, including y_b=0.
REQ-017 SHALL hold x_b stable between results; x_b changes only in DONE or on reset.
REQ-018 SHALL accept a new start on edge N+10 if start=1 then; start held high continuously gives one result every 10 cycles.
REQ-019 SHALL use 16-bit accumulator arithmetic with no overflow: max y_b*y_b = 65025.

Reset
REQ-020 SHALL on rst=1 at any edge, including mid-WORK or DONE: state IDLE, x_b=0, err=0, accumulator and counter=0; ready=1, busy=0 after that edge; in-flight operation discarded with no result written.
REQ-021 SHALL give rst priority over start on the same edge.

Configuration
REQ-022 SHALL, with macro SQUARE_REM_EN defined, add rem_b and err: result = y_b*y_b + rem_b, the exact inverse of integer sqrt with remainder; rem_b is added to the accumulator in DONE.
REQ-023 SHALL, with SQUARE_REM_EN, check at acceptance whether rem_b > 2*y_b; if so, rem_b is not added, x_b = y_b*y_b, and err=1 is written in DONE; otherwise err=0 in DONE. err is held with x_b.
REQ-024 SHALL, with SQUARE_REM_EN and a valid rem_b, produce a result of at most 65535, so no overflow occurs.
REQ-025 SHALL, without SQUARE_REM_EN, have no rem_b or err ports, and x_b = y_b*y_b; timing is identical in both builds.

Verification
REQ-026 SHALL cover: rst, then y_b=0, start pulse -> busy for 9 cycles, ready at N+9, x_b=0.
REQ-027 SHALL cover: y_b=255 -> x_b=65025 at N+9; y_b=16 -> x_b=256; y_b=13 -> x_b=169.
REQ-028 SHALL cover: start held high for 30 cycles with y_b=3, then 7, then 200 -> results 9, 49, 40000 at 10-cycle spacing; start pulses while busy are ignored.
REQ-029 SHALL cover: rst asserted at N+4 mid-WORK -> x_b=0, ready=1, busy=0 the next cycle, and no later result is written.
REQ-030 SHALL cover, with SQUARE_REM_EN: y_b=255, rem_b=510 -> x_b=65535, err=0; y_b=255, rem_b=511 -> x_b=65025, err=1; y_b=0, rem_b=1 -> x_b=0, err=1.
REQ-031 SHALL cover: random y_b (and a valid rem_b) fed through the team's sqrt block -> the original root (and remainder) is recovered.
